// File: rtl/perceptron_seq_pkg.sv
// Shared definitions for the perceptron sequencer: FSM encodings, default error
// byte, result-file address width and the checksum helper.
package perceptron_seq_pkg;

  localparam int         RESULT_AW        = 4;
  localparam logic [7:0] ERR_BYTE_DEFAULT = 8'hEE;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_READ  = 3'd3,
    S_SEND  = 3'd4,
    S_TXW   = 3'd5,
    S_DONE  = 3'd6,
    S_CSUM  = 3'd7
  } state_e;

  // Which kind of byte is currently travelling through SEND/TXW.
  typedef enum logic [1:0] {
    SRC_RESULT = 2'd0,
    SRC_ERR    = 2'd1,
    SRC_CSUM   = 2'd2
  } src_e;

  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/perceptron_seq_wdog.sv
// Watchdog for the core: counts cycles while enabled, saturates at TIMEOUT-1
// and reports expiry from that terminal count.
module perceptron_seq_wdog
  import perceptron_seq_pkg::*;
#(
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins, otherwise count up to the terminal value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {CW{1'b0}};
    end else if (en && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/perceptron_seq.sv
// Sequencer between UART byte interfaces and the perceptron core.
// Optional response checksum byte: define PERCEPTRON_SEQ_CSUM_EN.
module perceptron_seq
  import perceptron_seq_pkg::*;
#(
  parameter int         N_OUT    = 15,
  parameter int         TIMEOUT  = 4096,
  parameter logic [7:0] ERR_BYTE = ERR_BYTE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  input  logic                 tx_busy,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  output logic                 core_start,
  output logic [7:0]           core_x,
  input  logic                 core_done,
  output logic [RESULT_AW-1:0] core_rd_addr,
  input  logic [7:0]           core_rd_data,
  output logic                 busy,
  output logic                 err,
  output logic [7:0]           drop_cnt
);

  localparam logic [RESULT_AW-1:0] LAST_IDX = RESULT_AW'(N_OUT - 1);

  state_e               state_q, state_d;
  src_e                 src_q, src_d;
  logic [RESULT_AW-1:0] idx_q, idx_d;
  logic [RESULT_AW-1:0] addr_q, addr_d;
  logic                 ph_q, ph_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic [7:0]           core_x_q, core_x_d;
  logic                 err_q, err_d;
  logic                 tx_start_q;
  logic                 core_start_q;
  logic                 busy_q;
  logic [7:0]           drop_cnt_q;
  logic                 tx_fire_s;
  logic                 wd_clr_s;
  logic                 wd_en_s;
  logic                 wd_expired_s;
`ifdef PERCEPTRON_SEQ_CSUM_EN
  logic [7:0]           csum_q;
`endif

  perceptron_seq_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (wd_clr_s),
    .en      (wd_en_s),
    .expired (wd_expired_s)
  );

  // Next-state and datapath decode; ph_q sequences the two-cycle READ and TXW states.
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    ph_d      = ph_q;
    tx_data_d = tx_data_q;
    core_x_d  = core_x_q;
    err_d     = err_q;
    tx_fire_s = 1'b0;
    wd_clr_s  = 1'b0;
    wd_en_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          core_x_d = rx_data;
          state_d  = S_START;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_START: begin
        wd_clr_s = 1'b1;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        wd_en_s = 1'b1;
        if (core_done) begin
          idx_d   = {RESULT_AW{1'b0}};
          addr_d  = {RESULT_AW{1'b0}};
          ph_d    = 1'b0;
          src_d   = SRC_RESULT;
          state_d = S_READ;
        end else if (wd_expired_s) begin
          err_d     = 1'b1;
          tx_data_d = ERR_BYTE;
          src_d     = SRC_ERR;
          state_d   = S_SEND;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_READ: begin
        if (!ph_q) begin
          ph_d = 1'b1;
        end else begin
          ph_d      = 1'b0;
          tx_data_d = core_rd_data;
          state_d   = S_SEND;
        end
      end
      S_SEND: begin
        if (!tx_busy) begin
          tx_fire_s = 1'b1;
          ph_d      = 1'b0;
          state_d   = S_TXW;
        end else begin
          state_d   = S_SEND;
        end
      end
      S_TXW: begin
        // The first TXW cycle is skipped: tx_busy only rises the cycle after tx_start.
        if (!ph_q) begin
          ph_d = 1'b1;
        end else if (!tx_busy) begin
          ph_d = 1'b0;
          case (src_q)
            SRC_RESULT: begin
              if (idx_q < LAST_IDX) begin
                idx_d   = idx_q + 4'd1;
                addr_d  = idx_q + 4'd1;
                state_d = S_READ;
              end else begin
                state_d = S_DONE;
              end
            end
            SRC_ERR:  state_d = S_DONE;
            SRC_CSUM: state_d = S_IDLE;
            default:  state_d = S_IDLE;
          endcase
        end else begin
          state_d = S_TXW;
        end
      end
      S_DONE: begin
`ifdef PERCEPTRON_SEQ_CSUM_EN
        state_d = S_CSUM;
`else
        state_d = S_IDLE;
`endif
      end
      S_CSUM: begin
`ifdef PERCEPTRON_SEQ_CSUM_EN
        tx_data_d = csum_q;
        src_d     = SRC_CSUM;
        state_d   = S_SEND;
`else
        state_d   = S_IDLE;
`endif
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered output pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      src_q        <= SRC_RESULT;
      idx_q        <= {RESULT_AW{1'b0}};
      addr_q       <= {RESULT_AW{1'b0}};
      ph_q         <= 1'b0;
      tx_data_q    <= 8'h00;
      core_x_q     <= 8'h00;
      err_q        <= 1'b0;
      tx_start_q   <= 1'b0;
      core_start_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      idx_q        <= idx_d;
      addr_q       <= addr_d;
      ph_q         <= ph_d;
      tx_data_q    <= tx_data_d;
      core_x_q     <= core_x_d;
      err_q        <= err_d;
      tx_start_q   <= tx_fire_s;
      core_start_q <= (state_d == S_START);
      busy_q       <= (state_d != S_IDLE);
    end
  end

  // Saturating count of host bytes that arrive outside IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_q <= 8'h00;
    end else if (rx_valid && (state_q != S_IDLE) && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_q <= drop_cnt_q + 8'd1;
    end else begin
      drop_cnt_q <= drop_cnt_q;
    end
  end

`ifdef PERCEPTRON_SEQ_CSUM_EN
  // Running XOR of every byte handed to the transmitter in this response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_q <= 8'h00;
    end else if (state_q == S_START) begin
      csum_q <= 8'h00;
    end else if (tx_fire_s) begin
      csum_q <= csum_step(csum_q, tx_data_q);
    end else begin
      csum_q <= csum_q;
    end
  end
`endif

  assign tx_start     = tx_start_q;
  assign tx_data      = tx_data_q;
  assign core_start   = core_start_q;
  assign core_x       = core_x_q;
  assign core_rd_addr = addr_q;
  assign busy         = busy_q;
  assign err          = err_q;
  assign drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_perceptron_seq.sv
// Directed self-checking bench for perceptron_seq with a behavioural core and UART model.
module tb_perceptron_seq;

  localparam int N_OUT = 15;
`ifdef PERCEPTRON_SEQ_CSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       core_start;
  logic [7:0] core_x;
  logic       core_done;
  logic [3:0] core_rd_addr;
  logic [7:0] core_rd_data;
  logic       busy;
  logic       err;
  logic [7:0] drop_cnt;

  int         n_tests = 0;
  int         n_fail  = 0;

  // model knobs
  int         core_delay = 100;
  bit         core_hang  = 1'b0;
  logic [7:0] res_base   = 8'h10;
  int         busy_len   = 10;

  // model state
  int         core_cnt;
  bit         core_run;
  int         busy_cnt;
  int         tx_cnt    = 0;
  int         start_cnt = 0;
  int         viol      = 0;
  logic [7:0] tx_log [0:255];

  perceptron_seq #(
    .N_OUT    (15),
    .TIMEOUT  (4096),
    .ERR_BYTE (8'hEE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .tx_busy      (tx_busy),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .core_start   (core_start),
    .core_x       (core_x),
    .core_done    (core_done),
    .core_rd_addr (core_rd_addr),
    .core_rd_data (core_rd_data),
    .busy         (busy),
    .err          (err),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  // core model: done core_delay+1 cycles into WAIT, results res_base+addr
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      core_run <= 1'b0;
      core_cnt <= 0;
    end else if (core_start) begin
      core_run <= 1'b1;
      core_cnt <= core_delay;
    end else if (core_run) begin
      if (core_cnt == 0) core_run <= 1'b0;
      else core_cnt <= core_cnt - 1;
    end
  end
  assign core_done = core_run && (core_cnt == 0) && !core_hang;

  always @(posedge clk) core_rd_data <= res_base + {4'h0, core_rd_addr};

  // UART transmitter model
  always @(posedge clk or posedge rst) begin
    if (rst) busy_cnt <= 0;
    else if (tx_start) busy_cnt <= busy_len;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  always @(posedge clk) begin
    if (tx_start) begin
      if (tx_cnt < 256) tx_log[tx_cnt] <= tx_data;
      tx_cnt <= tx_cnt + 1;
    end
    if (tx_start && tx_busy) viol <= viol + 1;
    if (core_start) start_cnt <= start_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_tx_start"}, {31'd0, tx_start}, 32'd0);
    chk({tag, "_tx_data"}, {24'd0, tx_data}, 32'd0);
    chk({tag, "_core_start"}, {31'd0, core_start}, 32'd0);
    chk({tag, "_core_x"}, {24'd0, core_x}, 32'd0);
    chk({tag, "_rd_addr"}, {28'd0, core_rd_addr}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
    chk({tag, "_drop"}, {24'd0, drop_cnt}, 32'd0);
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int k = 0;
    while (busy && k < limit) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_idle_timeout"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_tx(input string tag, input int target, input int limit);
    int k = 0;
    while (tx_cnt < target && k < limit) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_tx_timeout"}, tx_cnt, target);
  endtask

  task automatic check_job(input string tag, input int t0, input logic [7:0] base);
    logic [7:0] x = 8'h00;
    chk({tag, "_count"}, tx_cnt - t0, N_OUT + CS);
    for (int k = 0; k < N_OUT; k++) begin
      chk($sformatf("%s_byte%0d", tag, k), {24'd0, tx_log[t0 + k]}, {24'd0, base + 8'(k)});
      x = x ^ (base + 8'(k));
    end
    if (CS == 1) chk({tag, "_csum"}, {24'd0, tx_log[t0 + N_OUT]}, {24'd0, x});
  endtask

  initial begin
    int t0;
    int s0;
    int k;
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk_zero_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: basic job
    t0 = tx_cnt; s0 = start_cnt;
    send_rx(8'h03);
    chk("t1_core_start", {31'd0, core_start}, 32'd1);
    chk("t1_core_x", {24'd0, core_x}, 32'h03);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    wait_idle("t1", 20000);
    chk("t1_starts", start_cnt - s0, 32'd1);
    check_job("t1", t0, 8'h10);
    chk("t1_err", {31'd0, err}, 32'd0);

    // 3: drops while running, then drop in the DONE cycle
    core_delay = 300;
    t0 = tx_cnt; s0 = start_cnt;
    send_rx(8'h40);
    repeat (20) @(negedge clk);
    send_rx(8'h77);
    repeat (5) @(negedge clk);
    send_rx(8'h78);
    repeat (5) @(negedge clk);
    send_rx(8'h79);
    chk("t3_drop3", {24'd0, drop_cnt}, 32'd3);
    wait_idle("t3a", 20000);
    chk("t3_starts", start_cnt - s0, 32'd1);
    check_job("t3a", t0, 8'h10);
    core_delay = 100;
    t0 = tx_cnt; s0 = start_cnt;
    send_rx(8'h41);
    chk("t3_accept_start", {31'd0, core_start}, 32'd1);
    chk("t3_accept_x", {24'd0, core_x}, 32'h41);
    wait_tx("t3b", t0 + N_OUT, 20000);
    k = 0;
    while (tx_busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    send_rx(8'h99);
    wait_idle("t3b", 2000);
    chk("t3_drop_done", {24'd0, drop_cnt}, 32'd4);
    chk("t3b_starts", start_cnt - s0, 32'd1);
    check_job("t3b", t0, 8'h10);

    // 4: slow transmitter
    busy_len = 1000; res_base = 8'h20;
    t0 = tx_cnt;
    send_rx(8'h05);
    wait_idle("t4", 30000);
    check_job("t4", t0, 8'h20);
    chk("t4_viol", viol, 32'd0);
    busy_len = 10;

    // 6b: core_done on the expiry cycle wins
    core_delay = 4095; res_base = 8'h10;
    t0 = tx_cnt;
    send_rx(8'h06);
    wait_idle("t6", 10000);
    chk("t6_err", {31'd0, err}, 32'd0);
    check_job("t6", t0, 8'h10);

    // 2: hung core -> error byte
    core_hang = 1'b1;
    t0 = tx_cnt;
    send_rx(8'h55);
    chk("t2_err_early", {31'd0, err}, 32'd0);
    k = 0;
    while (!err && k < 5000) begin
      @(negedge clk);
      k++;
    end
    chk("t2_err_cycle", k, 32'd4097);
    wait_idle("t2", 2000);
    chk("t2_err", {31'd0, err}, 32'd1);
    chk("t2_count", tx_cnt - t0, 32'(1 + CS));
    chk("t2_byte0", {24'd0, tx_log[t0]}, 32'hEE);
    if (CS == 1) chk("t2_byte1", {24'd0, tx_log[t0 + 1]}, 32'hEE);
    core_hang = 1'b0;

    // 5: reset mid-response
    core_delay = 50; res_base = 8'h30;
    t0 = tx_cnt;
    send_rx(8'h21);
    wait_tx("t5", t0 + 7, 5000);
    rst = 1'b1;
    #1;
    chk_zero_outputs("t5_rst");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("t5_no_more_tx", tx_cnt - t0, 32'd7);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    core_delay = 20; res_base = 8'h50;
    t0 = tx_cnt;
    send_rx(8'h22);
    chk("t5_x", {24'd0, core_x}, 32'h22);
    wait_idle("t5b", 20000);
    check_job("t5b", t0, 8'h50);
    chk("t5_err", {31'd0, err}, 32'd0);
    chk("final_viol", viol, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
